// File: rtl/alu_ctrl_decode.sv
// ID/EX decode-issue stage: decodes a 16-bit instruction into registered ALU control,
// resolves branches from the ALU zero flag, and flushes the wrong-path slot on a taken branch.
// Optional build macro ALU_CTRL_MUL_STALL_EN: MUL holds EX for two cycles.
module alu_ctrl_decode #(
  parameter int DSIZE = 16,
  parameter int RSIZE = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             if_valid,
  input  logic [15:0]      if_instr,
  input  logic [DSIZE-1:0] if_pc,
  input  logic             ex_stall,
  input  logic             zero,
  output logic             id_stall,
  output logic             ex_valid,
  output logic [2:0]       ex_op,
  output logic [DSIZE-1:0] ex_imm,
  output logic             ex_use_imm,
  output logic [RSIZE-1:0] ex_rd,
  output logic [RSIZE-1:0] ex_rs,
  output logic [RSIZE-1:0] ex_rt,
  output logic             ex_wen,
  output logic             ex_mem_rd,
  output logic             ex_mem_wr,
  output logic [DSIZE-1:0] ex_pc,
  output logic             br_taken,
  output logic [DSIZE-1:0] br_target,
  output logic             ill_instr
);

  typedef struct packed {
    logic             valid;
    logic [2:0]       op;
    logic [DSIZE-1:0] imm;
    logic             use_imm;
    logic [RSIZE-1:0] rd;
    logic [RSIZE-1:0] rs;
    logic [RSIZE-1:0] rt;
    logic             wen;
    logic             mem_rd;
    logic             mem_wr;
    logic             is_br;
    logic             is_bne;
    logic [DSIZE-1:0] pc;
  } ctrl_t;

  typedef enum logic {RUN, FLUSH} state_t;

  state_t     state;
  ctrl_t      ex_q, dec;
  logic       dec_ill;
  logic [3:0] opc, f1, f2, f3;

  assign opc = if_instr[15:12];
  assign f1  = if_instr[11:8];
  assign f2  = if_instr[7:4];
  assign f3  = if_instr[3:0];

  always_comb begin
    dec     = '0;
    dec_ill = 1'b0;
    dec.valid = 1'b1;
    dec.pc    = if_pc;
    case (opc)
      4'b0000, 4'b0001, 4'b0010, 4'b0011, 4'b0100, 4'b0101: begin
        dec.op  = opc[2:0];
        dec.rd  = RSIZE'(f1);
        dec.rs  = RSIZE'(f2);
        dec.rt  = RSIZE'(f3);
        dec.wen = 1'b1;
      end
      4'b0110, 4'b0111: begin
        dec.op      = opc[2:0];
        dec.rd      = RSIZE'(f1);
        dec.rs      = RSIZE'(f2);
        dec.imm     = {{(DSIZE-4){1'b0}}, f3};
        dec.use_imm = 1'b1;
        dec.wen     = 1'b1;
      end
      4'b1000: begin
        dec.op      = 3'd0;
        dec.rd      = RSIZE'(f1);
        dec.rs      = RSIZE'(f2);
        dec.imm     = {{(DSIZE-4){f3[3]}}, f3};
        dec.use_imm = 1'b1;
        dec.mem_rd  = 1'b1;
        dec.wen     = 1'b1;
      end
      4'b1001: begin
        dec.op      = 3'd0;
        dec.rt      = RSIZE'(f1);
        dec.rs      = RSIZE'(f2);
        dec.imm     = {{(DSIZE-4){f3[3]}}, f3};
        dec.use_imm = 1'b1;
        dec.mem_wr  = 1'b1;
      end
      4'b1100, 4'b1101: begin
        // Branch compares rs-rt in the ALU; offset rides in imm for the target adder
        dec.op     = 3'd1;
        dec.rs     = RSIZE'(f1);
        dec.rt     = RSIZE'(f2);
        dec.imm    = {{(DSIZE-4){f3[3]}}, f3};
        dec.is_br  = 1'b1;
        dec.is_bne = opc[0];
      end
      default: begin
        dec     = '0;
        dec_ill = 1'b1;
      end
    endcase
  end

`ifdef ALU_CTRL_MUL_STALL_EN
  logic mul_cnt;
  assign id_stall = ex_stall | mul_cnt;
`else
  assign id_stall = ex_stall;
`endif

  assign br_taken  = ex_q.valid & ex_q.is_br & ~ex_stall & (zero ^ ex_q.is_bne);
  assign br_target = ex_q.pc + DSIZE'(1) + ex_q.imm;

  always_ff @(posedge clk) begin
    if (rst) begin
      ex_q      <= '0;
      ill_instr <= 1'b0;
      state     <= RUN;
`ifdef ALU_CTRL_MUL_STALL_EN
      mul_cnt   <= 1'b0;
`endif
    end else if (br_taken) begin
      ex_q      <= '0;
      ill_instr <= 1'b0;
      state     <= FLUSH;
    end else if (id_stall) begin
      // Hold EX word and state; a pending MUL hold only advances once downstream frees
      ill_instr <= 1'b0;
`ifdef ALU_CTRL_MUL_STALL_EN
      if (!ex_stall) mul_cnt <= 1'b0;
`endif
    end else if (state == FLUSH) begin
      ex_q      <= '0;
      ill_instr <= 1'b0;
      state     <= RUN;
    end else if (if_valid) begin
      ex_q      <= dec_ill ? '0 : dec;
      ill_instr <= dec_ill;
`ifdef ALU_CTRL_MUL_STALL_EN
      mul_cnt   <= (opc == 4'b0101);
`endif
    end else begin
      ex_q      <= '0;
      ill_instr <= 1'b0;
    end
  end

  assign ex_valid   = ex_q.valid;
  assign ex_op      = ex_q.op;
  assign ex_imm     = ex_q.imm;
  assign ex_use_imm = ex_q.use_imm;
  assign ex_rd      = ex_q.rd;
  assign ex_rs      = ex_q.rs;
  assign ex_rt      = ex_q.rt;
  assign ex_wen     = ex_q.wen;
  assign ex_mem_rd  = ex_q.mem_rd;
  assign ex_mem_wr  = ex_q.mem_wr;
  assign ex_pc      = ex_q.pc;

endmodule

// File: tb/tb_alu_ctrl_decode.sv
// Scoreboard bench for alu_ctrl_decode: directed scenarios then random traffic,
// predicted by an instruction-level reference model.
module tb_alu_ctrl_decode;
  logic        clk = 1'b0;
  logic        rst, if_valid, ex_stall, zero;
  logic [15:0] if_instr, if_pc;
  logic        id_stall, ex_valid, ex_use_imm, ex_wen, ex_mem_rd, ex_mem_wr, br_taken, ill_instr;
  logic [2:0]  ex_op;
  logic [15:0] ex_imm, ex_pc, br_target;
  logic [3:0]  ex_rd, ex_rs, ex_rt;

  always #5 clk = ~clk;

  alu_ctrl_decode #(.DSIZE(16), .RSIZE(4)) dut (
    .clk(clk), .rst(rst), .if_valid(if_valid), .if_instr(if_instr), .if_pc(if_pc),
    .ex_stall(ex_stall), .zero(zero), .id_stall(id_stall), .ex_valid(ex_valid),
    .ex_op(ex_op), .ex_imm(ex_imm), .ex_use_imm(ex_use_imm), .ex_rd(ex_rd),
    .ex_rs(ex_rs), .ex_rt(ex_rt), .ex_wen(ex_wen), .ex_mem_rd(ex_mem_rd),
    .ex_mem_wr(ex_mem_wr), .ex_pc(ex_pc), .br_taken(br_taken), .br_target(br_target),
    .ill_instr(ill_instr)
  );

  typedef struct packed {
    logic        v;
    logic [2:0]  op;
    logic [15:0] imm;
    logic        ui;
    logic [3:0]  rd, rs, rt;
    logic        wen, mrd, mwr;
    logic [15:0] pc;
    logic        ill;
  } word_t;

  typedef struct packed {
    word_t       w;
    logic        ids;
    logic        bt;
    logic [15:0] tgt;
  } obs_t;

  obs_t  expq[$];
  int    checks = 0, errors = 0, cyc = 0;

  // Reference model state: architectural EX word plus branch kind, flush slot, MUL hold
  word_t cur;
  bit    m_br, m_bne, m_flush, m_mul, mv = 0;

  function automatic word_t ref_decode(input logic [15:0] ins, input logic [15:0] pc,
                                       output bit ill, output bit br, output bit bne);
    word_t w = '0;
    int opc = int'(ins[15:12]);
    int off = (ins[3:0] >= 8) ? int'(ins[3:0]) - 16 : int'(ins[3:0]);
    ill = 0; br = 0; bne = 0;
    w.v = 1; w.pc = pc;
    if (opc <= 5) begin
      w.op = 3'(opc); w.rd = ins[11:8]; w.rs = ins[7:4]; w.rt = ins[3:0]; w.wen = 1;
    end else if (opc == 6 || opc == 7) begin
      w.op = 3'(opc); w.rd = ins[11:8]; w.rs = ins[7:4]; w.imm = 16'(ins[3:0]); w.ui = 1; w.wen = 1;
    end else if (opc == 8) begin
      w.rd = ins[11:8]; w.rs = ins[7:4]; w.imm = 16'(off); w.ui = 1; w.mrd = 1; w.wen = 1;
    end else if (opc == 9) begin
      w.rt = ins[11:8]; w.rs = ins[7:4]; w.imm = 16'(off); w.ui = 1; w.mwr = 1;
    end else if (opc == 12 || opc == 13) begin
      w.op = 3'd1; w.rs = ins[11:8]; w.rt = ins[7:4]; w.imm = 16'(off);
      br = 1; bne = (opc == 13);
    end else begin
      w = '0; w.ill = 1; ill = 1;
    end
    return w;
  endfunction

  task automatic step(input bit r, input bit v, input logic [15:0] ins, input logic [15:0] pc,
                      input bit st, input bit z);
    obs_t e;
    bit ill, br, bne, taken, hold;
    rst = r; if_valid = v; if_instr = ins; if_pc = pc; ex_stall = st; zero = z;
    hold  = st | m_mul;
    taken = cur.v & m_br & !st & (z ^ m_bne);
    if (mv) begin
      e.w = cur; e.ids = hold; e.bt = taken; e.tgt = cur.pc + 16'd1 + cur.imm;
      expq.push_back(e);
    end
    if (r) begin
      cur = '0; m_br = 0; m_bne = 0; m_flush = 0; m_mul = 0;
    end else if (taken) begin
      cur = '0; m_br = 0; m_bne = 0; m_flush = 1; m_mul = 0;
    end else if (hold) begin
      cur.ill = 0;
      if (!st) m_mul = 0;
    end else if (m_flush || !v) begin
      cur = '0; m_br = 0; m_bne = 0; m_flush = 0;
    end else begin
      cur = ref_decode(ins, pc, ill, br, bne);
      m_br = br; m_bne = bne;
`ifdef ALU_CTRL_MUL_STALL_EN
      m_mul = (ins[15:12] == 4'd5);
`endif
    end
    mv = 1;
    @(posedge clk); #1;
    cyc++;
  endtask

  always @(negedge clk) begin
    if (expq.size() > 0) begin
      obs_t e, a;
      e = expq.pop_front();
      a.w = '{ex_valid, ex_op, ex_imm, ex_use_imm, ex_rd, ex_rs, ex_rt, ex_wen,
              ex_mem_rd, ex_mem_wr, ex_pc, ill_instr};
      a.ids = id_stall; a.bt = br_taken; a.tgt = br_target;
      checks++;
      if (a !== e) begin
        errors++;
        $display("FAIL ex_word cycle %0d: got v=%b op=%0d imm=%h ui=%b rd=%h rs=%h rt=%h wen=%b mrd=%b mwr=%b pc=%h ill=%b ids=%b bt=%b tgt=%h, exp v=%b op=%0d imm=%h ui=%b rd=%h rs=%h rt=%h wen=%b mrd=%b mwr=%b pc=%h ill=%b ids=%b bt=%b tgt=%h",
          cyc, a.w.v, a.w.op, a.w.imm, a.w.ui, a.w.rd, a.w.rs, a.w.rt, a.w.wen, a.w.mrd, a.w.mwr, a.w.pc, a.w.ill, a.ids, a.bt, a.tgt,
          e.w.v, e.w.op, e.w.imm, e.w.ui, e.w.rd, e.w.rs, e.w.rt, e.w.wen, e.w.mrd, e.w.mwr, e.w.pc, e.w.ill, e.ids, e.bt, e.tgt);
      end
    end
  end

  initial begin
    logic [15:0] pc;
    cur = '0; m_br = 0; m_bne = 0; m_flush = 0; m_mul = 0;
    // reset with a valid instruction present, then ADD decodes
    step(1, 1, 16'h0123, 16'h0000, 0, 0);
    step(0, 1, 16'h0123, 16'h0001, 0, 0);
    step(0, 1, 16'h645F, 16'h0002, 0, 0);
    step(0, 1, 16'h8A2C, 16'h0003, 0, 0);
    // BEQ taken: wrong-path and flush-slot instructions discarded
    step(0, 1, 16'hC12E, 16'h0010, 0, 0);
    step(0, 1, 16'h0123, 16'h0011, 0, 1);
    step(0, 1, 16'h1456, 16'h0012, 0, 0);
    step(0, 1, 16'h2789, 16'h000F, 0, 0);
    // BNE with zero=1 not taken, followed by SUB
    step(0, 1, 16'hD34F, 16'h0020, 0, 0);
    step(0, 1, 16'h1234, 16'h0021, 0, 1);
    // stall with SUB in EX and a branch pending at fetch
    step(0, 1, 16'hC000, 16'hFFFF, 1, 1);
    step(0, 1, 16'hC000, 16'hFFFF, 1, 1);
    step(0, 1, 16'hC000, 16'hFFFF, 1, 1);
    step(0, 1, 16'hC000, 16'hFFFF, 0, 0);
    // branch at 0xFFFF stalled once in EX, then taken with wrap-around target
    step(0, 1, 16'h3111, 16'h0000, 1, 1);
    step(0, 1, 16'h3111, 16'h0000, 0, 1);
    step(0, 0, 16'h0000, 16'h0000, 0, 0);
    // illegal opcode, then MUL, then normal traffic
    step(0, 1, 16'hE000, 16'h0030, 0, 0);
    step(0, 1, 16'h5123, 16'h0031, 0, 0);
    step(0, 1, 16'h9A3F, 16'h0032, 0, 0);
    step(0, 1, 16'h9A3F, 16'h0032, 0, 0);
    step(0, 1, 16'h7321, 16'h0033, 0, 0);
    // MUL hold frozen under ex_stall
    step(0, 1, 16'h5456, 16'h0040, 0, 0);
    step(0, 1, 16'h4111, 16'h0041, 1, 0);
    step(0, 1, 16'h4111, 16'h0041, 0, 0);
    step(0, 1, 16'h4111, 16'h0041, 0, 0);
    step(0, 1, 16'hF00F, 16'h0042, 0, 0);
    step(0, 0, 16'h0000, 16'h0000, 0, 0);
    pc = 16'h0100;
    for (int i = 0; i < 600; i++) begin
      bit r, v, st, z;
      logic [15:0] ins;
      r   = ($urandom_range(0, 99) < 2);
      v   = ($urandom_range(0, 99) < 80);
      st  = ($urandom_range(0, 99) < 20);
      z   = $urandom_range(0, 1);
      ins = 16'($urandom);
      if ($urandom_range(0, 9) == 0) pc = 16'($urandom);
      step(r, v, ins, pc, st, z);
      pc = pc + 16'd1;
    end
    step(0, 0, 16'h0000, 16'h0000, 0, 0);
    @(negedge clk);
    checks++;
    if (expq.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: got %0d pending, exp 0", expq.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
